// File: rtl/ls148_irq_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ls148_irq_encoder: synchronised 8-to-3 priority encoder with IRQ          |
// | handshake. Macro LS148_IRQ_ENCODER_EDGE_EN selects sticky edge capture.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module ls148_irq_encoder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       nEI,
    input  logic [7:0] nI,
    input  logic       nACK,
    output logic [2:0] nA,
    output logic       nGS,
    output logic       nEO,
    output logic       nINT,
    output logic [7:0] PENDING
);

    localparam logic [1:0] c_stateIdle = 2'd0;
    localparam logic [1:0] c_stateReq  = 2'd1;
    localparam logic [1:0] c_stateHold = 2'd2;

    logic [7:0] r_syncChain [SYNC_STAGES];
    logic [7:0] w_syncOut;
    logic [7:0] r_pending;
    logic [7:0] w_pendNext;
    logic [1:0] r_state;
    logic [1:0] w_stateNext;
    logic [2:0] r_code;
    logic [2:0] w_winner;
    logic       w_load;
    logic       r_nGS;
    logic       r_nEO;

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_syncChain[k] <= 8'hFF;
            end
        end else begin
            r_syncChain[0] <= nI;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_syncChain[k] <= r_syncChain[k-1];
            end
        end
    end

    assign w_syncOut = r_syncChain[SYNC_STAGES-1];

`ifdef LS148_IRQ_ENCODER_EDGE_EN
    logic [7:0] r_syncPrev;
    logic [7:0] w_pendSet;
    logic [7:0] w_pendClr;

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            r_syncPrev <= 8'hFF;
        end else begin
            r_syncPrev <= w_syncOut;
        end
    end

    assign w_pendSet = r_syncPrev & ~w_syncOut;

    always_comb begin
        w_pendClr = 8'h00;
        if (r_state == c_stateReq && !nACK) begin
            w_pendClr[r_code] = 1'b1;
        end
    end

    // Set is OR-ed in after the clear so a coincident new edge survives.
    assign w_pendNext = (r_pending & ~w_pendClr) | w_pendSet;
`else
    assign w_pendNext = ~w_syncOut;
`endif

    always_comb begin
        w_winner = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (r_pending[i]) begin
                w_winner = 3'(i);
            end
        end
    end

    assign w_load = (r_state == c_stateIdle) && !nEI && (r_pending != 8'h00);

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            r_pending <= 8'h00;
            r_nGS     <= 1'b1;
            r_nEO     <= 1'b1;
            r_code    <= 3'd0;
        end else begin
            r_pending <= w_pendNext;
            r_nGS     <= nEI | ~|w_pendNext;
            r_nEO     <= nEI | (|w_pendNext);
            if (w_load) begin
                r_code <= w_winner;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            r_state <= c_stateIdle;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_stateIdle: if (w_load) w_stateNext = c_stateReq;
            c_stateReq: begin
                // Acknowledge takes precedence over a simultaneous disable.
                if (!nACK) begin
                    w_stateNext = c_stateHold;
                end else if (nEI) begin
                    w_stateNext = c_stateIdle;
                end
            end
            c_stateHold: w_stateNext = c_stateIdle;
            default:     w_stateNext = c_stateIdle;
        endcase
    end

    always_comb begin
        nINT    = (r_state != c_stateReq);
        nA      = ~r_code;
        nGS     = r_nGS;
        nEO     = r_nEO;
        PENDING = r_pending;
    end

endmodule
`default_nettype wire

// File: doc/ls148_irq_encoder.md
# ls148_irq_encoder

- Synchronous 8-line to 3-line priority encoder with interrupt handshake.
- Encoding side of the TTL decoder pair: takes eight active-low request lines and presents the highest-priority one as an active-low 3-bit code, with LS148-style nGS/nEO flags.
- Each presented request is held until the consumer acknowledges it.
- Used in the System86 simulation wherever asynchronous board-level request lines are arbitrated onto a CPU interrupt/vector path.

## Interface
- SYNC_STAGES, 2, number of input synchroniser flops (legal range 1..4).
- CLK  input  1  system clock; all state updates on rising edge.
- nRESET  input  1  synchronous active-low reset, sampled on the CLK rising edge.
- nEI  input  1  active-low enable in; high blocks new requests and forces nGS/nEO high.
- nI  input  8  active-low request lines, asynchronous to CLK; bit 7 has highest priority.
- nACK  input  1  active-low acknowledge, sampled each cycle, one cycle wide.
- nA  output  3  active-low code of the presented request; code 7 gives 3'b000.
- nGS  output  1  low when nEI is low and any request is pending.
- nEO  output  1  low when nEI is low and no request is pending.
- nINT  output  1  low while a request is presented (state REQ).
- PENDING  output  8  active-high pending request latches.

## Operation
- Synchroniser: each nI bit passes through SYNC_STAGES flops. On reset all flops load 1.
- Pending latch, edge mode (see Configuration):
  - A high-to-low transition at the synchroniser output sets PENDING[i].
  - An acknowledge clears the PENDING bit of the presented code.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- Priority: the encoder selects the highest-indexed set PENDING bit; its index is the winner code.
- State machine, 3 states; reset state IDLE:
  - IDLE: nINT=1. If nEI=0 and PENDING≠0, load the winner into the code register and go to REQ.
  - REQ: nINT=0 and nA=~code, frozen.
    - A higher-priority arrival does not change the code.
    - nACK=0: clear PENDING[code] and go to HOLD.
    - nEI=1 (with nACK=1): go to IDLE; PENDING is left unchanged.
    - If nACK=0 and nEI=1 in the same cycle, the ack wins.
  - HOLD: nINT=1 for exactly one cycle, then IDLE.
- nACK outside REQ is ignored.
- nA holds the last presented code outside REQ; it is 3'b111 after reset.
- nGS and nEO are registered every cycle from the next-state PENDING and nEI:
  - nGS = nEI | ~|PENDING
  - nEO = nEI | |PENDING
- Reset mid-operation returns to IDLE and clears PENDING in the same cycle, regardless of nACK.

## Timing
- Reset values: nA=3'b111, nGS=1, nEO=1, nINT=1, PENDING=8'h00, synchroniser all 1s, state IDLE.
- Latency for a falling nI[i] first sampled at edge 0:
  - synchroniser output low after edge SYNC_STAGES-1;
  - PENDING[i] set at edge SYNC_STAGES;
  - nINT=0 and nA valid at edge SYNC_STAGES+1 (from IDLE, nEI=0).
- nGS goes low at the same edge PENDING is set.
- Ack: nACK=0 sampled at edge K:
  - at edge K, nINT goes 1 and PENDING[code] clears;
  - at edge K+1, state returns to IDLE;
  - at edge K+2, nINT is low again if anything is still pending.
- Minimum request-to-request spacing: 3 cycles (REQ, HOLD, IDLE).

## Configuration
- Macro LS148_IRQ_ENCODER_EDGE_EN.
- Defined: edge-triggered sticky PENDING as described in Operation; the ack clears the bit.
- Undefined: level mode.
  - PENDING is a registered copy of the inverted synchroniser output.
  - The ack only advances the FSM and does not clear PENDING.
  - Sources must deassert before HOLD ends, or they are presented again.
  - Latencies are unchanged.

## Test plan
- Reset: hold nRESET=0 with nI=8'h00 and nEI=0 → nA=3'b111, nGS=1, nEO=1, nINT=1, PENDING=0. Release reset with nI all 1s → nEO=0 one cycle later.
- Single request, SYNC_STAGES=2: drive nI[5] low at edge 0 → PENDING=8'h20 at edge 2; nINT=0 and nA=3'b010 at edge 3. Pulse nACK → PENDING=0 and nINT=1 on that edge, with nEO=0.
- Priority and freeze: nI[2] low; once nINT=0 and nA=3'b101, drive nI[6] low → nA stays 3'b101 until ack. After HOLD → nA=3'b001.
- Simultaneous set/clear (edge mode): re-assert a falling edge on bit 3 in the cycle its ack clears it → PENDING[3] stays 1 and is re-presented after HOLD.
- nEI gating: during REQ set nEI=1 → next edge nINT=1, nGS=1, nEO=1, PENDING unchanged. Set nEI=0 → request re-presented 1 cycle later.
- Reset mid-REQ: nRESET=0 while nINT=0 and nACK=0 → all outputs return to reset values on that edge.
